gci_std_display_vram_arbiter: RTL and testbench

//  Shares the single VRAM interface between two masters: M0 = display refresh reader (high priority),
//  M1 = bus-side request controller (low priority). Both use the REQ/ACK/FINISH/BREAK ownership handshake.

---
 rtl/gci_std_display_vram_arbiter_if.sv | 27 ++
 rtl/gci_std_display_vram_arbiter.sv | 128 ++++++++++++
 tb/tb_gci_std_display_vram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gci_std_display_vram_arbiter_if.sv
// VRAM master-side ownership and access bundle.
// The arbiter takes the slave modport, each requester the master modport.
interface gci_std_display_vram_arbiter_if #(
  parameter int P_MEM_ADDR_N = 23
);
  logic                    REQ;
  logic                    ACK;
  logic                    FINISH;
  logic                    BREAK;
  logic                    ENA;
  logic                    RW;
  logic [P_MEM_ADDR_N-1:0] ADDR;
  logic [23:0]             DATA;
  logic                    BUSY;
  logic                    VALID;
  logic [31:0]             RDATA;

  modport master (
    output REQ, FINISH, ENA, RW, ADDR, DATA,
    input  ACK, BREAK, BUSY, VALID, RDATA
  );

  modport slave (
    input  REQ, FINISH, ENA, RW, ADDR, DATA,
    output ACK, BREAK, BUSY, VALID, RDATA
  );
endinterface

// File: rtl/gci_std_display_vram_arbiter.sv
// Two-master VRAM arbiter: display refresh (M0, high prio)
// and bus-side controller (M1), with in-flight read tracking.
module gci_std_display_vram_arbiter #(
  parameter int P_MEM_ADDR_N = 23,
  parameter int P_M1_MIN_CYC = 16,
  parameter int P_OUTSTD_MAX = 8
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  gci_std_display_vram_arbiter_if.slave m0_if,
  gci_std_display_vram_arbiter_if.slave m1_if,
  output logic                    oMEM_ENA,
  output logic                    oMEM_RW,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [23:0]             oMEM_DATA,
  input  logic                    iMEM_BUSY,
  input  logic                    iMEM_VALID,
  input  logic [31:0]             iMEM_DATA
);

  localparam int CW = $clog2(P_M1_MIN_CYC + 1);
  localparam logic [CW-1:0] MIN_CYC = CW'(P_M1_MIN_CYC);
  localparam logic [3:0] RD_MAX = 4'(P_OUTSTD_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_OWN, S_BREAK, S_DRAIN
  } state_t;

  state_t          state_q;
  logic            owner_q;
  logic [CW-1:0]   own_cnt_q;
  logic [3:0]      rd_cnt_q, rd_cnt_d;
  logic            ack0_q, ack1_q, brk_q;

  logic                    active, rd_full;
  logic                    own_ena, own_rw, own_fin;
  logic [P_MEM_ADDR_N-1:0] own_addr;
  logic [23:0]             own_data;
  logic                    stall, accept, ret;

  always_comb begin
    active   = (state_q == S_OWN) || (state_q == S_BREAK);
    own_ena  = owner_q ? m1_if.ENA    : m0_if.ENA;
    own_rw   = owner_q ? m1_if.RW     : m0_if.RW;
    own_fin  = owner_q ? m1_if.FINISH : m0_if.FINISH;
    own_addr = owner_q ? m1_if.ADDR   : m0_if.ADDR;
    own_data = owner_q ? m1_if.DATA   : m0_if.DATA;
    rd_full  = (rd_cnt_q == RD_MAX);
    stall    = iMEM_BUSY || (!own_rw && rd_full);
    // the releasing cycle never issues an access
    oMEM_ENA  = active && own_ena && !own_fin && !stall;
    oMEM_RW   = active && own_rw;
    oMEM_ADDR = active ? own_addr : '0;
    oMEM_DATA = active ? own_data : '0;
    accept   = oMEM_ENA && !oMEM_RW;
    ret      = iMEM_VALID && (rd_cnt_q != 4'd0);
    rd_cnt_d = rd_cnt_q + {3'd0, accept} - {3'd0, ret};
  end

  assign m0_if.ACK   = ack0_q;
  assign m1_if.ACK   = ack1_q;
  assign m0_if.BREAK = 1'b0;
  assign m1_if.BREAK = brk_q;
  assign m0_if.BUSY  = !(active && !owner_q) || iMEM_BUSY
                       || (!m0_if.RW && rd_full);
  assign m1_if.BUSY  = !(active && owner_q) || iMEM_BUSY
                       || (!m1_if.RW && rd_full);
  assign m0_if.VALID = ret && !owner_q;
  assign m1_if.VALID = ret && owner_q;
  assign m0_if.RDATA = iMEM_DATA;
  assign m1_if.RDATA = iMEM_DATA;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      own_cnt_q <= '0;
      rd_cnt_q  <= 4'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (m0_if.REQ) begin
            owner_q <= 1'b0;
            ack0_q  <= 1'b1;
            state_q <= S_GRANT;
          end else if (m1_if.REQ) begin
            owner_q <= 1'b1;
            ack1_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          own_cnt_q <= '0;
          state_q   <= S_OWN;
        end
        S_OWN: begin
          if (own_cnt_q != MIN_CYC)
            own_cnt_q <= own_cnt_q + CW'(1);
          if (own_fin) begin
            state_q <= S_DRAIN;
          end else if (owner_q && m0_if.REQ
                       && own_cnt_q >= MIN_CYC) begin
            brk_q   <= 1'b1;
            state_q <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (m1_if.FINISH) begin
            brk_q   <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_cnt_d == 4'd0)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Directed bench for the VRAM arbiter: grant order, break,
// outstanding-read limit, routing and asynchronous reset.
module tb_gci_std_display_vram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gci_std_display_vram_arbiter_if m0 ();
  gci_std_display_vram_arbiter_if m1 ();

  logic        mem_ena, mem_rw, mem_busy, mem_valid;
  logic [22:0] mem_addr;
  logic [23:0] mem_data;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  gci_std_display_vram_arbiter dut (
    .iCLOCK    (clk),
    .inRESET   (rst_n),
    .m0_if     (m0),
    .m1_if     (m1),
    .oMEM_ENA  (mem_ena),
    .oMEM_RW   (mem_rw),
    .oMEM_ADDR (mem_addr),
    .oMEM_DATA (mem_data),
    .iMEM_BUSY (mem_busy),
    .iMEM_VALID(mem_valid),
    .iMEM_DATA (mem_rdata)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clr;
    m0.REQ = 0; m0.FINISH = 0; m0.ENA = 0; m0.RW = 0;
    m0.ADDR = '0; m0.DATA = '0;
    m1.REQ = 0; m1.FINISH = 0; m1.ENA = 0; m1.RW = 0;
    m1.ADDR = '0; m1.DATA = '0;
    mem_busy = 0; mem_valid = 0; mem_rdata = '0;
  endtask

  task release_owner(input bit x);
    if (x) m1.FINISH = 1; else m0.FINISH = 1;
    m0.ENA = 0; m1.ENA = 0;
    tick;
    m0.FINISH = 0; m1.FINISH = 0;
    tick;
  endtask

  task test_reset;
    logic [7:0] v;
    clr;
    rst_n = 0;
    tick; tick;
    v = {m0.ACK, m1.ACK, m0.BREAK, m1.BREAK,
         m0.VALID, m1.VALID, mem_ena, mem_rw};
    n_cmp++;
    if (v !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 00000000", v);
    end
    n_cmp++;
    if ({m0.BUSY, m1.BUSY} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_busy: got %b want 11", {m0.BUSY, m1.BUSY});
    end
    n_cmp++;
    if ({mem_addr, mem_data} !== 47'd0) begin
      n_bad++;
      $display("FAIL rst_bus: got %h/%h want 0/0", mem_addr, mem_data);
    end
    rst_n = 1;
    tick;
  endtask

  task test_m1_alone;
    bit ok;
    m1.REQ = 1;
    tick;
    n_cmp++;
    if ({m0.ACK, m1.ACK} !== 2'b01) begin
      n_bad++;
      $display("FAIL t1_ack: got %b want 01", {m0.ACK, m1.ACK});
    end
    m1.REQ = 0;
    tick;
    n_cmp++;
    if ({m1.ACK, m1.BUSY, m0.BUSY} !== 3'b001) begin
      n_bad++;
      $display("FAIL t1_own: got %b want 001",
               {m1.ACK, m1.BUSY, m0.BUSY});
    end
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      m1.ENA = 1; m1.RW = 1;
      m1.ADDR = 23'h10 + 23'(i);
      m1.DATA = 24'hABC000 + 24'(i);
      #1;
      if (mem_ena !== 1'b1 || mem_rw !== 1'b1
          || mem_addr !== 23'h10 + 23'(i)
          || mem_data !== 24'hABC000 + 24'(i)) begin
        ok = 0;
        $display("FAIL t1_wr%0d: got %b %b %h %h want 1 1 %h %h",
                 i, mem_ena, mem_rw, mem_addr, mem_data,
                 23'h10 + 23'(i), 24'hABC000 + 24'(i));
      end
      tick;
    end
    n_cmp++;
    if (!ok) n_bad++;
    mem_busy = 1; m1.ADDR = 23'h14;
    #1;
    n_cmp++;
    if ({mem_ena, m1.BUSY} !== 2'b01) begin
      n_bad++;
      $display("FAIL t1_membusy: got %b want 01", {mem_ena, m1.BUSY});
    end
    mem_busy = 0; m1.FINISH = 1;
    #1;
    n_cmp++;
    if (mem_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_fin_ena: got %b want 0", mem_ena);
    end
    tick;
    clr;
    #1;
    n_cmp++;
    if ({m1.BUSY, mem_ena} !== 2'b10) begin
      n_bad++;
      $display("FAIL t1_drain: got %b want 10", {m1.BUSY, mem_ena});
    end
    tick; tick;
    n_cmp++;
    if ({m0.ACK, m1.ACK, m1.BUSY} !== 3'b001) begin
      n_bad++;
      $display("FAIL t1_idle: got %b want 001",
               {m0.ACK, m1.ACK, m1.BUSY});
    end
  endtask

  task test_both_req;
    int n;
    m0.REQ = 1; m1.REQ = 1;
    tick;
    n_cmp++;
    if ({m0.ACK, m1.ACK} !== 2'b10) begin
      n_bad++;
      $display("FAIL t2_ack: got %b want 10", {m0.ACK, m1.ACK});
    end
    m0.REQ = 0;
    tick;
    m0.ENA = 1; m0.RW = 1; m0.ADDR = 23'h22;
    m1.ENA = 1; m1.RW = 1; m1.ADDR = 23'h55;
    #1;
    n_cmp++;
    if ({mem_ena, mem_addr, m0.BUSY, m1.BUSY} !== {1'b1, 23'h22, 2'b01}) begin
      n_bad++;
      $display("FAIL t2_mux: got %b %h %b%b want 1 22 01",
               mem_ena, mem_addr, m0.BUSY, m1.BUSY);
    end
    m0.FINISH = 1; m0.ENA = 0; m1.ENA = 0;
    tick;
    m0.FINISH = 0;
    n = 1;
    while (!m1.ACK && n < 10) begin
      tick;
      n++;
    end
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL t2_m1_ack_lat: got %0d want 3", n);
    end
    m1.REQ = 0;
    tick;
    release_owner(1);
  endtask

  task test_break;
    int n;
    bit ok;
    m1.REQ = 1;
    tick;
    m1.REQ = 0;
    tick;
    n = 0;
    while (!m1.BREAK && n < 40) begin
      if (n == 2) m0.REQ = 1;
      tick;
      n++;
    end
    n_cmp++;
    if (n !== 17) begin
      n_bad++;
      $display("FAIL t3_break_at: got %0d want 17", n);
    end
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      m1.ENA = 1; m1.RW = 1; m1.ADDR = 23'h77;
      #1;
      if ({m1.BREAK, mem_ena, m0.ACK, m1.BUSY} !== 4'b1100
          || mem_addr !== 23'h77) begin
        ok = 0;
        $display("FAIL t3_hold%0d: got %b %h want 1100 77", i,
                 {m1.BREAK, mem_ena, m0.ACK, m1.BUSY}, mem_addr);
      end
      tick;
    end
    n_cmp++;
    if (!ok) n_bad++;
    m1.FINISH = 1; m1.ENA = 0;
    tick;
    m1.FINISH = 0;
    #1;
    n_cmp++;
    if (m1.BREAK !== 1'b0) begin
      n_bad++;
      $display("FAIL t3_break_clr: got %b want 0", m1.BREAK);
    end
    tick; tick;
    n_cmp++;
    if ({m0.ACK, m1.ACK} !== 2'b10) begin
      n_bad++;
      $display("FAIL t3_m0_ack: got %b want 10", {m0.ACK, m1.ACK});
    end
    m0.REQ = 0;
    tick;
    release_owner(0);
  endtask

  task test_outstanding;
    int acc;
    bit seen, ok;
    m0.REQ = 1;
    tick;
    m0.REQ = 0;
    tick;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      m0.ENA = 1; m0.RW = 0; m0.ADDR = 23'h100 + 23'(i);
      #1;
      if (mem_ena) acc++;
      if (i == 8) begin
        n_cmp++;
        if ({m0.BUSY, mem_ena} !== 2'b10) begin
          n_bad++;
          $display("FAIL t4_full: got %b want 10", {m0.BUSY, mem_ena});
        end
      end
      tick;
    end
    n_cmp++;
    if (acc !== 8) begin
      n_bad++;
      $display("FAIL t4_accepted: got %0d want 8", acc);
    end
    m0.ENA = 0; m0.FINISH = 1; m1.REQ = 1;
    tick;
    m0.FINISH = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (m1.ACK) seen = 1;
      tick;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_drain_hold: got %b want 0", seen);
    end
    ok = 1;
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1; mem_rdata = 32'hD000_0000 + 32'(i);
      #1;
      if ({m0.VALID, m1.VALID, m1.ACK} !== 3'b100
          || m0.RDATA !== 32'hD000_0000 + 32'(i)) begin
        ok = 0;
        $display("FAIL t4_ret%0d: got %b %h want 100 %h", i,
                 {m0.VALID, m1.VALID, m1.ACK}, m0.RDATA,
                 32'hD000_0000 + 32'(i));
      end
      tick;
    end
    n_cmp++;
    if (!ok) n_bad++;
    mem_valid = 0;
    tick;
    n_cmp++;
    if (m1.ACK !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_m1_ack: got %b want 1", m1.ACK);
    end
    m1.REQ = 0;
    tick;
  endtask

  task test_concurrent;
    m1.ENA = 1; m1.RW = 0; m1.ADDR = 23'h200;
    #1;
    n_cmp++;
    if (mem_ena !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_rd0: got %b want 1", mem_ena);
    end
    tick;
    m1.ADDR = 23'h201; mem_valid = 1; mem_rdata = 32'hBEEF_0001;
    #1;
    n_cmp++;
    if ({mem_ena, m0.VALID, m1.VALID} !== 3'b101
        || m1.RDATA !== 32'hBEEF_0001) begin
      n_bad++;
      $display("FAIL t5_both: got %b %h want 101 beef0001",
               {mem_ena, m0.VALID, m1.VALID}, m1.RDATA);
    end
    tick;
    m1.ENA = 0; mem_rdata = 32'hBEEF_0002;
    #1;
    n_cmp++;
    if ({m0.VALID, m1.VALID} !== 2'b01) begin
      n_bad++;
      $display("FAIL t5_last: got %b want 01", {m0.VALID, m1.VALID});
    end
    tick;
    mem_rdata = 32'hBEEF_0003;
    #1;
    n_cmp++;
    if ({m0.VALID, m1.VALID} !== 2'b00) begin
      n_bad++;
      $display("FAIL t5_spurious: got %b want 00", {m0.VALID, m1.VALID});
    end
    tick;
    mem_valid = 0;
    release_owner(1);
  endtask

  task test_reset_mid;
    bit ok;
    m0.REQ = 1;
    tick;
    m0.REQ = 0;
    tick;
    for (int i = 0; i < 3; i++) begin
      m0.ENA = 1; m0.RW = 0; m0.ADDR = 23'h300 + 23'(i);
      tick;
    end
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({mem_ena, m0.BUSY, m1.BUSY, m0.ACK, m1.ACK, m1.BREAK} !== 6'b011000
        || mem_addr !== 23'd0) begin
      n_bad++;
      $display("FAIL t6_async: got %b %h want 011000 0",
               {mem_ena, m0.BUSY, m1.BUSY, m0.ACK, m1.ACK, m1.BREAK},
               mem_addr);
    end
    clr;
    tick;
    rst_n = 1;
    tick;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_rdata = 32'hCAFE_0000 + 32'(i);
      #1;
      if ({m0.VALID, m1.VALID} !== 2'b00) begin
        ok = 0;
        $display("FAIL t6_drop%0d: got %b want 00", i,
                 {m0.VALID, m1.VALID});
      end
      tick;
    end
    n_cmp++;
    if (!ok) n_bad++;
    mem_valid = 0;
    m1.REQ = 1;
    tick;
    n_cmp++;
    if ({m0.ACK, m1.ACK} !== 2'b01) begin
      n_bad++;
      $display("FAIL t6_resume: got %b want 01", {m0.ACK, m1.ACK});
    end
    m1.REQ = 0;
    tick;
    release_owner(1);
  endtask

  initial begin
    test_reset;
    test_m1_alone;
    test_both_req;
    test_break;
    test_outstanding;
    test_concurrent;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
